arm_multicycle_ctrl: RTL and testbench

- Parametrised multicycle control unit for the ARM-subset datapath.
- Replaces bench-driven control vectors with an FSM that sequences fetch/decode/execute from instruction fields.
- Holds a registered NZCV flag register and evaluates condition codes, giving real conditional execution (BLT, conditional data-processing, loads and stores).
- Supports a selectable ALU operation set.

---
 rtl/arm_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control unit for the ARM-subset datapath: sequences fetch/decode/execute,
// holds the NZCV flag register and gates every write strobe with the instruction condition.
module arm_multicycle_ctrl #(
  parameter int ALUCTRL_W  = 2,
  parameter int ENABLE_CMP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ImmSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ResultSrc,
  output logic [3:0]           Flags,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } stateT;

  stateT                state;
  logic                 condEx;
  logic                 condHold;
  logic                 cmdSupported;
  logic                 cmdIsCmp;
  logic                 cmdArith;
  logic [ALUCTRL_W-1:0] aluOp;
  logic                 inExecute;
  logic                 nzWe;
  logic                 cvWe;
  logic                 wbEn;
  logic                 pcWriteS;
  logic                 memWriteS;
  logic                 irWriteS;
  logic                 regWriteS;

  // Data-processing command decode; unsupported commands fall back to ADD with no side effects.
  always_comb begin
    cmdSupported = 1'b0;
    cmdIsCmp     = 1'b0;
    cmdArith     = 1'b0;
    aluOp        = '0;
    case (Funct[4:1])
      4'b0100: begin cmdSupported = 1'b1; cmdArith = 1'b1; end
      4'b0010: begin cmdSupported = 1'b1; cmdArith = 1'b1; aluOp = ALUCTRL_W'(1); end
      4'b0001: begin cmdSupported = 1'b1; aluOp = ALUCTRL_W'(2); end
      4'b0000: begin cmdSupported = 1'b1; aluOp = ALUCTRL_W'(3); end
      4'b1100: begin
        if (ALUCTRL_W >= 3) begin
          cmdSupported = 1'b1;
          aluOp        = ALUCTRL_W'(4);
        end
      end
      4'b1010: begin
        if (ENABLE_CMP != 0) begin
          cmdSupported = 1'b1;
          cmdIsCmp     = 1'b1;
          cmdArith     = 1'b1;
          aluOp        = ALUCTRL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Condition evaluation always uses the registered flags, never the live ALU flags.
  always_comb begin
    case (Cond)
      4'b0000: condEx = Flags[2];
      4'b0001: condEx = ~Flags[2];
      4'b0010: condEx = Flags[1];
      4'b0011: condEx = ~Flags[1];
      4'b0100: condEx = Flags[3];
      4'b0101: condEx = ~Flags[3];
      4'b0110: condEx = Flags[0];
      4'b0111: condEx = ~Flags[0];
      4'b1000: condEx = Flags[1] & ~Flags[2];
      4'b1001: condEx = ~Flags[1] | Flags[2];
      4'b1010: condEx = (Flags[3] == Flags[0]);
      4'b1011: condEx = (Flags[3] != Flags[0]);
      4'b1100: condEx = ~Flags[2] & (Flags[3] == Flags[0]);
      4'b1101: condEx = Flags[2] | (Flags[3] != Flags[0]);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  assign inExecute = (state == EXECUTER) || (state == EXECUTEI);
  assign nzWe      = inExecute && condEx && cmdSupported && (Funct[0] || cmdIsCmp);
  assign cvWe      = nzWe && cmdArith;
  assign wbEn      = condHold && cmdSupported && !cmdIsCmp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      Flags    <= 4'b0000;
      condHold <= 1'b0;
    end else begin
      case (state)
        FETCH:   state <= DECODE;
        DECODE: begin
          case (Op)
            2'b00:   state <= Funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:  state <= Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD: state <= MEMWB;
        EXECUTER, EXECUTEI: begin
          state    <= ALUWB;
          // Writeback must see the pre-instruction condition even though flags change here.
          condHold <= condEx;
          if (nzWe) Flags[3:2] <= ALUFlags[3:2];
          if (cvWe) Flags[1:0] <= ALUFlags[1:0];
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pcWriteS   = 1'b0;
    memWriteS  = 1'b0;
    irWriteS   = 1'b0;
    regWriteS  = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = 2'b00;
    ImmSrc     = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = '0;
    ResultSrc  = 2'b00;
    case (state)
      FETCH: begin
        irWriteS  = 1'b1;
        pcWriteS  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegSrc    = {Op == 2'b01, Op == 2'b10};
        ImmSrc    = Op;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        regWriteS = condEx;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        memWriteS = condEx;
      end
      EXECUTER: ALUControl = aluOp;
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = aluOp;
      end
      ALUWB: begin
        // A write to R15 is redirected into the PC.
        pcWriteS  = wbEn && (Rd == 4'hF);
        regWriteS = wbEn && (Rd != 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcWriteS  = condEx;
      end
      default: ;
    endcase
  end

  assign PCWrite  = pcWriteS & reset;
  assign MemWrite = memWriteS & reset;
  assign IRWrite  = irWriteS & reset;
  assign RegWrite = regWriteS & reset;
  assign State    = state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: two parameterisations run in lockstep against an
// instruction-level reference model, plus a fixed vector table and a mid-instruction reset.
module tb_arm_multicycle_ctrl;

  typedef logic [24:0] obs_t;

  typedef struct {
    logic [3:0] c;
    logic [1:0] o;
    logic [5:0] f;
    logic [3:0] r;
    logic [3:0] af;
    int         lat;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [2:0] la;
    logic [2:0] lb;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;

  logic       a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_alu_src_a;
  logic [1:0] a_reg_src, a_imm_src, a_alu_src_b, a_alu_control, a_result_src;
  logic [3:0] a_flags, a_state;
  logic       b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write, b_alu_src_a;
  logic [1:0] b_reg_src, b_imm_src, b_alu_src_b, b_result_src;
  logic [2:0] b_alu_control;
  logic [3:0] b_flags, b_state;

  logic [24:0] exp_a_q[$];
  logic [24:0] exp_b_q[$];
  logic [3:0]  mflags_a, mflags_b;
  int          checks = 0;
  int          passed = 0;
  logic        rw_watch = 1'b0;
  logic        rw_seen  = 1'b0;
  vec_t        vecs[16];
  logic [3:0]  cmds[8];

  arm_multicycle_ctrl #(.ALUCTRL_W(2), .ENABLE_CMP(1)) dut_a (
    .clk(clk), .reset(reset), .Cond(cond), .Op(op), .Funct(funct), .Rd(rd), .ALUFlags(alu_flags),
    .PCWrite(a_pc_write), .AdrSrc(a_adr_src), .MemWrite(a_mem_write), .IRWrite(a_ir_write),
    .RegWrite(a_reg_write), .RegSrc(a_reg_src), .ImmSrc(a_imm_src), .ALUSrcA(a_alu_src_a),
    .ALUSrcB(a_alu_src_b), .ALUControl(a_alu_control), .ResultSrc(a_result_src),
    .Flags(a_flags), .State(a_state)
  );

  arm_multicycle_ctrl #(.ALUCTRL_W(3), .ENABLE_CMP(0)) dut_b (
    .clk(clk), .reset(reset), .Cond(cond), .Op(op), .Funct(funct), .Rd(rd), .ALUFlags(alu_flags),
    .PCWrite(b_pc_write), .AdrSrc(b_adr_src), .MemWrite(b_mem_write), .IRWrite(b_ir_write),
    .RegWrite(b_reg_write), .RegSrc(b_reg_src), .ImmSrc(b_imm_src), .ALUSrcA(b_alu_src_a),
    .ALUSrcB(b_alu_src_b), .ALUControl(b_alu_control), .ResultSrc(b_result_src),
    .Flags(b_flags), .State(b_state)
  );

  // clock / reset-window monitor
  always #5 clk = ~clk;

  always @(a_reg_write or b_reg_write) begin
    if (rw_watch && (a_reg_write || b_reg_write)) rw_seen = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  function automatic obs_t obs_a();
    return {a_state, a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_reg_src,
            a_imm_src, a_alu_src_a, a_alu_src_b, {1'b0, a_alu_control}, a_result_src, a_flags};
  endfunction

  function automatic obs_t obs_b();
    return {b_state, b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write, b_reg_src,
            b_imm_src, b_alu_src_a, b_alu_src_b, b_alu_control, b_result_src, b_flags};
  endfunction

  // strobes = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite}; rsimm = {RegSrc, ImmSrc}; srcs = {ALUSrcA, ALUSrcB}
  function automatic obs_t mk(input logic [3:0] st, input logic [4:0] strobes, input logic [3:0] rsimm,
                              input logic [2:0] srcs, input logic [2:0] alu, input logic [1:0] res,
                              input logic [3:0] fl);
    return {st, strobes, rsimm, srcs, alu, res, fl};
  endfunction

  // ARM conditions: cond[3:1] picks a base predicate, cond[0] inverts it; 1111 never executes.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v;
    logic [7:0] base;
    {n, z, cy, v} = fl;
    base = {1'b1, !z && (n == v), n == v, cy && !z, v, n, cy, z};
    if (c == 4'hF) return 1'b0;
    return base[c[3:1]] ^ c[0];
  endfunction

  task automatic push(input bit sel, input obs_t v);
    if (sel) exp_b_q.push_back(v);
    else exp_a_q.push_back(v);
  endtask

  // Reference model: expected per-cycle outputs for one whole instruction, updates model flags.
  task automatic model_instr(input bit sel, input int w, input bit cmp_en, input logic [3:0] c,
                             input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                             input logic [3:0] af, inout logic [3:0] fl);
    logic ok, sup, cmp, arith, wr;
    logic [2:0] alu;
    logic [3:0] mask;
    ok = cond_model(c, fl);
    push(sel, mk(4'd0, 5'b10010, 4'b0000, 3'b110, 3'd0, 2'b10, fl));
    push(sel, mk(4'd1, 5'b00000, {o == 2'b01, o == 2'b10, o}, 3'b110, 3'd0, 2'b10, fl));
    case (o)
      2'b01: begin
        push(sel, mk(4'd2, 5'b00000, 4'b0000, 3'b001, 3'd0, 2'b00, fl));
        if (f[0]) begin
          push(sel, mk(4'd3, 5'b01000, 4'b0000, 3'b000, 3'd0, 2'b00, fl));
          push(sel, mk(4'd4, {4'b0000, ok}, 4'b0000, 3'b000, 3'd0, 2'b01, fl));
        end else begin
          push(sel, mk(4'd5, {2'b01, ok, 2'b00}, 4'b0000, 3'b000, 3'd0, 2'b00, fl));
        end
      end
      2'b00: begin
        sup = 1'b0; cmp = 1'b0; arith = 1'b0; alu = 3'd0;
        case (f[4:1])
          4'b0100: begin sup = 1'b1; arith = 1'b1; end
          4'b0010: begin sup = 1'b1; arith = 1'b1; alu = 3'd1; end
          4'b0001: begin sup = 1'b1; alu = 3'd2; end
          4'b0000: begin sup = 1'b1; alu = 3'd3; end
          4'b1100: if (w >= 3) begin sup = 1'b1; alu = 3'd4; end
          4'b1010: if (cmp_en) begin sup = 1'b1; cmp = 1'b1; arith = 1'b1; alu = 3'd1; end
          default: ;
        endcase
        push(sel, mk(f[5] ? 4'd7 : 4'd6, 5'b00000, 4'b0000, {1'b0, 1'b0, f[5]}, alu, 2'b00, fl));
        mask = arith ? 4'hF : 4'hC;
        if (ok && sup && (f[0] || cmp)) fl = (fl & ~mask) | (af & mask);
        wr = ok && sup && !cmp;
        push(sel, mk(4'd8, {wr && (r == 4'hF), 3'b000, wr && (r != 4'hF)}, 4'b0000, 3'b000, 3'd0,
                     2'b00, fl));
      end
      2'b10: push(sel, mk(4'd9, {ok, 4'b0000}, 4'b0000, 3'b001, 3'd0, 2'b10, fl));
      default: ;
    endcase
  endtask

  // driver: apply one instruction, compare every cycle until the DUT returns to FETCH
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af,
                           output int lat, output logic [2:0] la, output logic [2:0] lb);
    obs_t e;
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
    model_instr(1'b0, 2, 1'b1, c, o, f, r, af, mflags_a);
    model_instr(1'b1, 3, 1'b0, c, o, f, r, af, mflags_b);
    lat = 0; la = '0; lb = '0;
    do begin
      @(negedge clk);
      e = (exp_a_q.size() != 0) ? exp_a_q.pop_front() : '1;
      check($sformatf("cycle_a_c%0d_op%0d_s%0d", lat, o, a_state), 32'(obs_a()), 32'(e));
      e = (exp_b_q.size() != 0) ? exp_b_q.pop_front() : '1;
      check($sformatf("cycle_b_c%0d_op%0d_s%0d", lat, o, b_state), 32'(obs_b()), 32'(e));
      la = {a_pc_write, a_reg_write, a_mem_write};
      lb = {b_pc_write, b_reg_write, b_mem_write};
      lat++;
      @(posedge clk); #1;
    end while (a_state != 4'd0 && lat < 12);
    check("trace_len_a", 32'(exp_a_q.size()), 32'd0);
    check("trace_len_b", 32'(exp_b_q.size()), 32'd0);
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  initial begin
    int         lat, k;
    logic [2:0] la, lb;
    logic [3:0] rc, rr, raf;
    logic [1:0] ro;
    logic [5:0] rf;
    int         exp_lat;

    reset = 1'b0; cond = '0; op = '0; funct = '0; rd = '0; alu_flags = '0;
    mflags_a = '0; mflags_b = '0;
    cmds = '{4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1100, 4'b1010, 4'b1111, 4'b0111};
    //           c      o      f          r      af       lat fa       fb       la      lb
    vecs[0]  = '{4'hE, 2'b00, 6'b101000, 4'd1,  4'b0000, 4, 4'b0000, 4'b0000, 3'b010, 3'b010};
    vecs[1]  = '{4'hE, 2'b00, 6'b000101, 4'd3,  4'b1000, 4, 4'b1000, 4'b1000, 3'b010, 3'b010};
    vecs[2]  = '{4'hB, 2'b10, 6'b000000, 4'd0,  4'b0000, 3, 4'b1000, 4'b1000, 3'b100, 3'b100};
    vecs[3]  = '{4'hE, 2'b00, 6'b001001, 4'd4,  4'b0000, 4, 4'b0000, 4'b0000, 3'b010, 3'b010};
    vecs[4]  = '{4'hB, 2'b10, 6'b000000, 4'd0,  4'b0000, 3, 4'b0000, 4'b0000, 3'b000, 3'b000};
    vecs[5]  = '{4'hE, 2'b00, 6'b001001, 4'd4,  4'b0010, 4, 4'b0010, 4'b0010, 3'b010, 3'b010};
    vecs[6]  = '{4'hE, 2'b00, 6'b100011, 4'd5,  4'b0111, 4, 4'b0110, 4'b0110, 3'b010, 3'b010};
    vecs[7]  = '{4'hE, 2'b00, 6'b011000, 4'd2,  4'b1111, 4, 4'b0110, 4'b0110, 3'b000, 3'b010};
    vecs[8]  = '{4'hE, 2'b00, 6'b110101, 4'd0,  4'b1001, 4, 4'b1001, 4'b0110, 3'b000, 3'b000};
    vecs[9]  = '{4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000, 4, 4'b1001, 4'b0110, 3'b100, 3'b100};
    vecs[10] = '{4'hE, 2'b01, 6'b011001, 4'd1,  4'b0000, 5, 4'b1001, 4'b0110, 3'b010, 3'b010};
    vecs[11] = '{4'hE, 2'b01, 6'b011000, 4'd1,  4'b0000, 4, 4'b1001, 4'b0110, 3'b001, 3'b001};
    vecs[12] = '{4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 2, 4'b1001, 4'b0110, 3'b000, 3'b000};
    vecs[13] = '{4'h1, 2'b00, 6'b000101, 4'd6,  4'b0100, 4, 4'b0100, 4'b0110, 3'b010, 3'b000};
    vecs[14] = '{4'h0, 2'b00, 6'b101000, 4'd7,  4'b0000, 4, 4'b0100, 4'b0110, 3'b010, 3'b010};
    vecs[15] = '{4'hF, 2'b00, 6'b101000, 4'd7,  4'b0000, 4, 4'b0100, 4'b0110, 3'b000, 3'b000};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state_a", 32'(a_state), 32'd0);
    check("rst_flags_a", 32'(a_flags), 32'd0);
    check("rst_strobes_a", 32'({a_pc_write, a_mem_write, a_reg_write, a_ir_write}), 32'd0);
    check("rst_strobes_b", 32'({b_pc_write, b_mem_write, b_reg_write, b_ir_write}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].c, vecs[i].o, vecs[i].f, vecs[i].r, vecs[i].af, lat, la, lb);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_flags_a", i), 32'(a_flags), 32'(vecs[i].fa));
      check($sformatf("v%0d_flags_b", i), 32'(b_flags), 32'(vecs[i].fb));
      check($sformatf("v%0d_last_a", i), 32'(la), 32'(vecs[i].la));
      check($sformatf("v%0d_last_b", i), 32'(lb), 32'(vecs[i].lb));
    end

    // reset asserted while an ADD sits in EXECUTER
    cond = 4'hE; op = 2'b00; funct = 6'b001000; rd = 4'd2; alu_flags = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_exec_state", 32'(a_state), 32'd6);
    rw_seen = 1'b0;
    rw_watch = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_state_a", 32'(a_state), 32'd0);
    check("abort_state_b", 32'(b_state), 32'd0);
    check("abort_flags_a", 32'(a_flags), 32'd0);
    check("abort_flags_b", 32'(b_flags), 32'd0);
    check("abort_strobes_a", 32'({a_pc_write, a_mem_write, a_reg_write, a_ir_write}), 32'd0);
    op = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("held_state_a", 32'(a_state), 32'd0);
    reset = 1'b1;
    rw_watch = 1'b0;
    check("abort_no_regwrite", 32'(rw_seen), 32'd0);
    mflags_a = '0;
    mflags_b = '0;

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 9);
      ro  = (k < 5) ? 2'b00 : (k < 7) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
      rc  = 4'($urandom_range(0, 15));
      rr  = (k == 0) ? 4'hF : 4'($urandom_range(0, 15));
      raf = 4'($urandom_range(0, 15));
      rf  = {1'($urandom_range(0, 1)), cmds[$urandom_range(0, 7)], 1'($urandom_range(0, 1))};
      exp_lat = (ro == 2'b00) ? 4 : (ro == 2'b01) ? (rf[0] ? 5 : 4) : (ro == 2'b10) ? 3 : 2;
      run_instr(rc, ro, rf, rr, raf, lat, la, lb);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
